// File: rtl/eq_ctrl_pkg.sv
// Shared types, widths and default timing for the equalizer level controller.
package eq_ctrl_pkg;

  localparam int EQ_LEVEL_W = 6;

  localparam int unsigned DEB_CYC_DEF       = 16;
  localparam int unsigned ENTER_LOW_CYC_DEF = 4;
  localparam int unsigned HOLD_CYC_DEF      = 4;
  localparam int          LEVEL_MAX_DEF     = 31;
  localparam int          LEVEL_RST_DEF     = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMMIT  = 2'd1,
    HOLDOFF = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    BASS = 2'd0,
    MID  = 2'd1,
    TREB = 2'd2
  } band_t;

  typedef logic signed [EQ_LEVEL_W-1:0] level_t;
  typedef logic signed [EQ_LEVEL_W:0]   level_wide_t;

  // One extra bit of headroom so +1/-1 never wraps before the clamp.
  function automatic level_t step_level(input level_t cur, input logic inc,
                                        input logic dec, input int max_lvl);
    level_wide_t wide;
    level_wide_t lim;
    wide = {cur[EQ_LEVEL_W-1], cur};
    lim  = level_wide_t'(max_lvl);
    if (inc && !dec) begin
      wide = wide + 7'sd1;
    end else if (dec && !inc) begin
      wide = wide - 7'sd1;
    end
    if (wide > lim) begin
      wide = lim;
    end else if (wide < -lim) begin
      wide = -lim;
    end
    return $signed(wide[EQ_LEVEL_W-1:0]);
  endfunction

  function automatic band_t next_band(input band_t cur);
    case (cur)
      BASS:    return MID;
      MID:     return TREB;
      default: return BASS;
    endcase
  endfunction

endpackage

// File: rtl/eq_level_ctrl_if.sv
// Button inputs and equalizer-facing outputs of the level controller.
interface eq_level_ctrl_if;
  import eq_ctrl_pkg::*;

  logic   btn_up;
  logic   btn_down;
  logic   btn_band;
  logic   btn_enter;
  level_t bass_level;
  level_t mid_level;
  level_t treble_level;
  logic   enter;
  logic [1:0] band_sel;
  logic   busy;

  modport master (
    output btn_up, btn_down, btn_band, btn_enter,
    input  bass_level, mid_level, treble_level, enter, band_sel, busy
  );

  modport slave (
    input  btn_up, btn_down, btn_band, btn_enter,
    output bass_level, mid_level, treble_level, enter, band_sel, busy
  );

endinterface

// File: rtl/eq_btn_cond.sv
// Raw button conditioning: 2-flop synchronizer, optional debounce, rising-edge press.
// Debounce counter is built only when EQ_LEVEL_CTRL_DEBOUNCE_EN is defined.
module eq_btn_cond #(
  parameter int unsigned DEB_CYC = eq_ctrl_pkg::DEB_CYC_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic press
);

  logic sync_1;
  logic sync_2;
  logic level_q;
  logic level_prev;

  if (DEB_CYC < 2 || DEB_CYC > 65535) begin : g_deb_cyc_range
    $error("eq_btn_cond: DEB_CYC must be within 2..65535");
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_1 <= 1'b0;
      sync_2 <= 1'b0;
    end else begin
      sync_1 <= btn_raw;
      sync_2 <= sync_1;
    end
  end

`ifdef EQ_LEVEL_CTRL_DEBOUNCE_EN
  logic [15:0] deb_cnt;

  // Down-counter reloads whenever the input agrees with the debounced state,
  // so only an unbroken run of DEB_CYC differing cycles flips it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_q <= 1'b0;
      deb_cnt <= 16'(DEB_CYC - 1);
    end else if (sync_2 == level_q) begin
      deb_cnt <= 16'(DEB_CYC - 1);
    end else if (deb_cnt == 16'd0) begin
      level_q <= sync_2;
      deb_cnt <= 16'(DEB_CYC - 1);
    end else begin
      deb_cnt <= deb_cnt - 16'd1;
    end
  end
`else
  assign level_q = sync_2;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_prev <= 1'b0;
    end else begin
      level_prev <= level_q;
    end
  end

  assign press = level_q & ~level_prev;

endmodule

// File: rtl/eq_level_ctrl.sv
// Push-button front end for the equalizer: band select, saturating levels, enter strobe.
// Build option EQ_LEVEL_CTRL_DEBOUNCE_EN enables per-button debounce in eq_btn_cond.
//
// state   | meaning
// IDLE    | accept presses, adjust levels / band, enter press starts a commit
// COMMIT  | enter held low, levels and band frozen
// HOLDOFF | enter back high, levels still frozen, presses dropped
module eq_level_ctrl
  import eq_ctrl_pkg::*;
#(
  parameter int unsigned DEB_CYC       = DEB_CYC_DEF,
  parameter int unsigned ENTER_LOW_CYC = ENTER_LOW_CYC_DEF,
  parameter int unsigned HOLD_CYC      = HOLD_CYC_DEF,
  parameter int          LEVEL_MAX     = LEVEL_MAX_DEF,
  parameter int          LEVEL_RST     = LEVEL_RST_DEF
) (
  input logic             clk,
  input logic             rst_n,
  eq_level_ctrl_if.slave  bus
);

  logic press_up;
  logic press_down;
  logic press_band;
  logic press_enter;

  eq_btn_cond #(.DEB_CYC(DEB_CYC)) u_cond_up (
    .clk(clk), .rst_n(rst_n), .btn_raw(bus.btn_up), .press(press_up)
  );
  eq_btn_cond #(.DEB_CYC(DEB_CYC)) u_cond_down (
    .clk(clk), .rst_n(rst_n), .btn_raw(bus.btn_down), .press(press_down)
  );
  eq_btn_cond #(.DEB_CYC(DEB_CYC)) u_cond_band (
    .clk(clk), .rst_n(rst_n), .btn_raw(bus.btn_band), .press(press_band)
  );
  eq_btn_cond #(.DEB_CYC(DEB_CYC)) u_cond_enter (
    .clk(clk), .rst_n(rst_n), .btn_raw(bus.btn_enter), .press(press_enter)
  );

  state_t      state;
  logic [15:0] tmr;
  level_t      bass_q;
  level_t      mid_q;
  level_t      treb_q;
  band_t       band_q;
  logic        enter_q;
  logic        busy_q;

  // Reset parks the FSM in COMMIT with the timer one above its normal load,
  // so the first edge after release drops enter for a full ENTER_LOW_CYC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= COMMIT;
      tmr     <= 16'(ENTER_LOW_CYC);
      bass_q  <= level_t'(LEVEL_RST);
      mid_q   <= level_t'(LEVEL_RST);
      treb_q  <= level_t'(LEVEL_RST);
      band_q  <= BASS;
      enter_q <= 1'b1;
      busy_q  <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (press_up || press_down) begin
            case (band_q)
              BASS:    bass_q <= step_level(bass_q, press_up, press_down, LEVEL_MAX);
              MID:     mid_q  <= step_level(mid_q,  press_up, press_down, LEVEL_MAX);
              default: treb_q <= step_level(treb_q, press_up, press_down, LEVEL_MAX);
            endcase
          end
          if (press_band) begin
            band_q <= next_band(band_q);
          end
          if (press_enter) begin
            state   <= COMMIT;
            tmr     <= 16'(ENTER_LOW_CYC - 1);
            enter_q <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        COMMIT: begin
          if (tmr == 16'd0) begin
            state   <= HOLDOFF;
            tmr     <= 16'(HOLD_CYC - 1);
            enter_q <= 1'b1;
          end else begin
            tmr     <= tmr - 16'd1;
            enter_q <= 1'b0;
          end
        end
        HOLDOFF: begin
          if (tmr == 16'd0) begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end else begin
            tmr <= tmr - 16'd1;
          end
        end
        default: begin
          state   <= IDLE;
          enter_q <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.bass_level   = bass_q;
  assign bus.mid_level    = mid_q;
  assign bus.treble_level = treb_q;
  assign bus.band_sel     = band_q;
  assign bus.enter        = enter_q;
  assign bus.busy         = busy_q;

endmodule
